// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the switch debouncer.
// Imported by the interface, the per-bit filter and the top level.
package sw_debounce_pkg;

    localparam int N_SW_DEF       = 18;
    localparam int TICK_DIV_DEF   = 50000;
    localparam int STABLE_CNT_DEF = 16;

    // Width holding 0..stableCnt, never narrower than one bit.
    function automatic int cntWidth(input int stableCnt);
        int w;
        w = $clog2(stableCnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-side bundle: raw pins in, debounced vector and change pulses out.
// master drives the raw pins; slave is the debouncer.
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int N_SW = N_SW_DEF
);

    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_db;
    logic            sw_changed;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_changed,
        input  sw_rise,
        input  sw_fall
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_changed,
        output sw_rise,
        output sw_fall
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch's stability counter and debounced flop.
// dbNext_o exposes the next-state value so the top can register edge pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_i,
    input  logic sync_i,
    output logic db_o,
    output logic dbNext_o
);

    localparam int             CW   = cntWidth(STABLE_CNT);
    localparam logic [CW-1:0]  LAST = CW'(STABLE_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q,  db_d;

    // Any agreeing sample throws away the partial count, so bounces restart it.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (tick_i) begin
            if (sync_i == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                db_d  = sync_i;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o     = db_q;
    assign dbNext_o = db_d;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW raw switch pins for the switch PIO.
// Define SW_DEBOUNCE_EDGE_EN to build per-bit rise/fall pulses; otherwise they read 0.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW       = N_SW_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    sw_debounce_if.slave sw
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [N_SW-1:0] syncMeta_q;
    logic [N_SW-1:0] sync_q;
    logic [PW-1:0]   prescale_q, prescale_d;
    logic            tick;
    logic [N_SW-1:0] db;
    logic [N_SW-1:0] dbNext;
    logic            changed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_q <= '0;
            sync_q     <= '0;
        end else begin
            syncMeta_q <= sw.sw_raw;
            sync_q     <= syncMeta_q;
        end
    end

    assign tick       = (prescale_q == PRE_LAST);
    assign prescale_d = tick ? '0 : prescale_q + PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick_i   (tick),
            .sync_i   (sync_q[i]),
            .db_o     (db[i]),
            .dbNext_o (dbNext[i])
        );
    end

    // Pulses are computed from the next state so they line up with the sw_db update edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |(dbNext ^ db);
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [N_SW-1:0] rise_q;
    logic [N_SW-1:0] fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= dbNext & ~db;
            fall_q <= ~dbNext & db;
        end
    end

    assign sw.sw_rise = rise_q;
    assign sw.sw_fall = fall_q;
`else
    assign sw.sw_rise = '0;
    assign sw.sw_fall = '0;
`endif

    assign sw.sw_db      = db;
    assign sw.sw_changed = changed_q;

endmodule
